// File: rtl/xor_cipher_pkg.sv
// xor_cipher_pkg: key-load FSM state encoding and a width-generic rotate-left helper.
package xor_cipher_pkg;
    localparam int MAX_W = 64;
    typedef enum logic [1:0] {S_NOKEY, S_RUN, S_DRAIN} state_e;
    // Rotate the low w bits of x left by amt; callers zero-extend into and truncate out of MAX_W.
    function automatic logic [MAX_W-1:0] rotl(input logic [MAX_W-1:0] x, input int amt, input int w);
        int n;
        logic [MAX_W-1:0] m;
        n = amt % w;
        m = {MAX_W{1'b1}} >> (MAX_W - w);
        return ((x << n) | ((x & m) >> (w - n))) & m;
    endfunction
endpackage

// File: rtl/xor_cipher_round.sv
// xor_cipher_round: one cipher stage, data/valid register fed by (data ^ rotl(key, IDX)) rotated by 1.
// Ports: clk, reset_n (async active-low), en_i (stage advance), valid_i/data_i (stage input),
//        key_i (installed key), valid_o/data_o (registered stage output).
module xor_cipher_round #(
    parameter int DATA_W = 8,
    parameter int IDX    = 0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              en_i,
    input  logic              valid_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic [DATA_W-1:0] key_i,
    output logic              valid_o,
    output logic [DATA_W-1:0] data_o
);
    import xor_cipher_pkg::*;
    logic [DATA_W-1:0] rk, d_d, d_q;
    logic v_q;
    assign rk  = DATA_W'(rotl(MAX_W'(key_i), IDX % DATA_W, DATA_W));
    assign d_d = DATA_W'(rotl(MAX_W'(data_i ^ rk), 1, DATA_W));
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            v_q <= 1'b0;
            d_q <= '0;
        end else if (en_i) begin
            v_q <= valid_i;
            d_q <= d_d;
        end
    end
    assign valid_o = v_q;
    assign data_o  = d_q;
endmodule

// File: rtl/xor_cipher_pipe.sv
// xor_cipher_pipe: ROUNDS-stage pipelined XOR/rotate cipher with valid/ready streaming and guarded key load.
// Ports: clk, reset_n (async active-low); key_in/key_load request a key, key_ack/key_err pulse the outcome,
//        keyed flags an installed key; in_data/in_valid/in_ready plaintext stream; out_data/out_valid/
//        out_ready ciphertext stream; blk_cnt counts delivered blocks (wraps).
// Option: define KEY_PARITY_CHECK_EN to store a key parity bit and add a sticky key_fault output that
//         blocks both stream handshakes until reset.
module xor_cipher_pipe #(
    parameter int DATA_W = 8,
    parameter int ROUNDS = 2,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [DATA_W-1:0] key_in,
    input  logic              key_load,
    output logic              key_ack,
    output logic              key_err,
    output logic              keyed,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CNT_W-1:0]  blk_cnt
`ifdef KEY_PARITY_CHECK_EN
    ,
    output logic              key_fault
`endif
);
    import xor_cipher_pkg::*;
    state_e state_q;
    logic [DATA_W-1:0] key_q;
    logic ack_q, err_q, advance, req, key_ok, drained, load, reject, fault;
    logic [CNT_W-1:0] cnt_q;
    logic [ROUNDS-1:0] sv;
    logic [DATA_W-1:0] sd [ROUNDS];
    // key_load is still high while its own ack/err pulse is visible; ignore it then so one request
    // yields exactly one outcome.
    assign req     = key_load & !ack_q & !err_q;
    assign key_ok  = |key_in;
    assign drained = (state_q == S_DRAIN) & key_load & ~|sv;
    assign load    = key_ok & (((state_q == S_NOKEY) & req) | drained);
    assign reject  = !key_ok & (((state_q == S_NOKEY) & req) | drained);
    assign out_valid = sv[ROUNDS-1] & !fault;
    assign out_data  = sd[ROUNDS-1];
    assign advance   = !out_valid | out_ready;
    assign in_ready  = advance & (state_q == S_RUN) & !key_load & !fault;
    assign keyed     = state_q != S_NOKEY;
    assign key_ack   = ack_q;
    assign key_err   = err_q;
    assign blk_cnt   = cnt_q;
    for (genvar g = 0; g < ROUNDS; g++) begin : g_round
        logic [DATA_W-1:0] d_in;
        logic v_in;
        if (g == 0) begin : g_first
            assign d_in = in_data;
            assign v_in = in_valid & in_ready;
        end else begin : g_next
            assign d_in = sd[g-1];
            assign v_in = sv[g-1];
        end
        xor_cipher_round #(.DATA_W(DATA_W), .IDX(g)) u_round (
            .clk(clk), .reset_n(reset_n), .en_i(advance), .valid_i(v_in),
            .data_i(d_in), .key_i(key_q), .valid_o(sv[g]), .data_o(sd[g])
        );
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_NOKEY;
            key_q   <= '0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            ack_q <= load;
            err_q <= reject;
            if (load) key_q <= key_in;
            case (state_q)
                S_NOKEY: if (load) state_q <= S_RUN;
                S_RUN:   if (req) state_q <= S_DRAIN;
                S_DRAIN: if (!key_load | drained) state_q <= S_RUN;
                default: state_q <= S_NOKEY;
            endcase
        end
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) cnt_q <= '0;
        else if (out_valid & out_ready) cnt_q <= cnt_q + CNT_W'(1);
    end
`ifdef KEY_PARITY_CHECK_EN
    logic par_q, fault_q;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            par_q   <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            if (load) par_q <= ^key_in;
            if (^key_q != par_q) fault_q <= 1'b1;
        end
    end
    assign fault     = fault_q;
    assign key_fault = fault_q;
`else
    assign fault = 1'b0;
`endif
endmodule

// File: tb/tb_xor_cipher_pipe.sv
// tb_xor_cipher_pipe: directed/random stimulus against a queue-based reference cipher model.
module tb_xor_cipher_pipe;
    localparam int DW = 8;
    localparam int RN = 2;
    logic clk = 0, reset_n = 0, key_load = 0, in_valid = 0, out_ready = 0;
    logic [DW-1:0] key_in = '0, in_data = '0, out_data;
    logic key_ack, key_err, keyed, in_ready, out_valid;
    logic [1:0] blk_cnt;
    int checks = 0, errors = 0, tot = 0, sent = 0, tot0;
    logic [DW-1:0] mkey = '0, held = '0;
    logic stall_pend = 0, took = 0;
    logic [DW-1:0] q[$];

    xor_cipher_pipe #(.DATA_W(DW), .ROUNDS(RN), .CNT_W(2)) dut (
        .clk(clk), .reset_n(reset_n), .key_in(key_in), .key_load(key_load), .key_ack(key_ack),
        .key_err(key_err), .keyed(keyed), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .blk_cnt(blk_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    function automatic logic [DW-1:0] rl(logic [DW-1:0] x, int n);
        int k = n % DW;
        int v = int'(x);
        return DW'(((v * (2 ** k)) % (2 ** DW)) + (v / (2 ** (DW - k))));
    endfunction

    function automatic logic [DW-1:0] cipher(logic [DW-1:0] p, logic [DW-1:0] k);
        for (int r = 0; r < RN; r++) p = rl(p ^ rl(k, r), 1);
        return p;
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: observe handshakes just after the inputs settle, then move to the next falling edge.
    task automatic cyc();
        #1;
        if (stall_pend) begin
            chk("hold_valid", 32'(out_valid), 32'(1'b1));
            chk("hold_data", 32'(out_data), 32'(held));
        end
        took = in_valid && in_ready;
        if (took) q.push_back(cipher(in_data, mkey));
        if (out_valid && out_ready) begin
            if (q.size() == 0) chk("unexpected_out", 32'(out_valid), 32'(1'b0));
            else chk("out_data", 32'(out_data), 32'(q.pop_front()));
            tot++;
        end
        stall_pend = out_valid && !out_ready;
        held = out_data;
        @(negedge clk);
    endtask

    task automatic wait_key(string tag, logic exp_ack);
        logic a = 0, e = 0;
        int n = 0;
        while (!(a || e) && n < 30) begin
            cyc();
            a = key_ack;
            e = key_err;
            n++;
        end
        chk({tag, "_ack"}, 32'(a), 32'(exp_ack));
        chk({tag, "_err"}, 32'(e), 32'(!exp_ack));
        key_load = 0;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_in_ready", 32'(in_ready), 0);
        chk("rst_keyed", 32'(keyed), 0);
        chk("rst_blk_cnt", 32'(blk_cnt), 0);
        chk("rst_ack_err", 32'({key_ack, key_err}), 0);
        @(negedge clk);
        reset_n = 1;
        // Data before key
        in_valid = 1;
        in_data = 8'h55;
        out_ready = 1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("nokey_in_ready", 32'(in_ready), 0);
            chk("nokey_out_valid", 32'(out_valid), 0);
        end
        in_valid = 0;
        // Zero key rejected, then 0x42 accepted
        key_load = 1;
        key_in = 8'h00;
        wait_key("zero_key", 0);
        chk("zero_keyed", 32'(keyed), 0);
        cyc();
        chk("err_one_cycle", 32'(key_err), 0);
        key_load = 1;
        key_in = 8'h42;
        wait_key("key42", 1);
        mkey = 8'h42;
        chk("key42_keyed", 32'(keyed), 1);
        cyc();
        chk("ack_one_cycle", 32'(key_ack), 0);
        // Known vectors with exact latency
        in_valid = 1;
        in_data = 8'h01;
        cyc();
        in_valid = 0;
        chk("lat1_no_out", 32'(out_valid), 0);
        cyc();
        chk("lat2_out_valid", 32'(out_valid), 1);
        chk("vec01", 32'(out_data), 32'(8'h04));
        in_valid = 1;
        in_data = 8'h00;
        cyc();
        in_valid = 0;
        cyc();
        chk("vec00_valid", 32'(out_valid), 1);
        chk("vec00", 32'(out_data), 0);
        cyc();
        chk("cnt_after_vec", 32'(blk_cnt), 32'(tot % 4));
        // Stream 4 random blocks with a 3-cycle sink stall
        sent = 0;
        for (int c = 0; c < 40 && (sent < 4 || q.size() > 0); c++) begin
            in_valid = sent < 4;
            in_data = DW'($urandom);
            out_ready = !(c >= 2 && c < 5);
            cyc();
            if (took) sent++;
        end
        in_valid = 0;
        out_ready = 1;
        chk("stream_sent", 32'(sent), 4);
        chk("stream_drained", 32'(q.size()), 0);
        chk("stream_cnt_wrap", 32'(blk_cnt), 32'(tot % 4));
        // Zero key while running: rejected, old key kept
        key_load = 1;
        key_in = 8'h00;
        wait_key("zero_run", 0);
        chk("zero_run_keyed", 32'(keyed), 1);
        // Rekey request withdrawn during drain: no pulse, key unchanged
        out_ready = 0;
        in_valid = 1;
        in_data = DW'($urandom);
        cyc();
        in_valid = 0;
        key_load = 1;
        key_in = 8'h99;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("abort_no_pulse", 32'({key_ack, key_err}), 0);
        end
        key_load = 0;
        cyc();
        out_ready = 1;
        repeat (3) cyc();
        chk("abort_no_pulse_after", 32'({key_ack, key_err}), 0);
        chk("abort_drained", 32'(q.size()), 0);
        // Rekey to 0x81 with two blocks in flight
        in_valid = 1;
        in_data = DW'($urandom);
        cyc();
        in_data = DW'($urandom);
        cyc();
        tot0 = tot;
        in_data = DW'($urandom);
        key_load = 1;
        key_in = 8'h81;
        #1;
        chk("rekey_in_ready_drop", 32'(in_ready), 0);
        wait_key("rekey81", 1);
        chk("rekey_old_outputs", 32'(tot - tot0), 2);
        chk("rekey_q_empty", 32'(q.size()), 0);
        mkey = 8'h81;
        cyc();
        in_data = 8'h01;
        cyc();
        in_valid = 0;
        repeat (4) cyc();
        chk("newkey_drained", 32'(q.size()), 0);
        chk("newkey_cnt", 32'(blk_cnt), 32'(tot % 4));
        // Reset mid-stream
        in_valid = 1;
        in_data = DW'($urandom);
        cyc();
        in_data = DW'($urandom);
        cyc();
        #2;
        reset_n = 0;
        #1;
        chk("midrst_out_valid", 32'(out_valid), 0);
        chk("midrst_out_data", 32'(out_data), 0);
        chk("midrst_keyed", 32'(keyed), 0);
        chk("midrst_blk_cnt", 32'(blk_cnt), 0);
        chk("midrst_in_ready", 32'(in_ready), 0);
        q.delete();
        stall_pend = 0;
        @(negedge clk);
        reset_n = 1;
        repeat (2) cyc();
        chk("postrst_keyed", 32'(keyed), 0);
        chk("postrst_out_valid", 32'(out_valid), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
